multicycle_controller: RTL

Multi-cycle successor to the single-cycle control path. It sequences each MIPS-subset instruction through fetch, decode, execute, memory and writeback states over a shared datapath with one memory port. Memory accesses wait on a ready handshake, bounded by a configurable timeout. It sits between the instruction register and the multi-cycle datapath, which holds the PC, IR, A/B, ALUOut and MDR registers.

---
 rtl/multicycle_controller.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS-subset control FSM with memory ready/timeout handling.
// Define PERF_COUNTER_EN to build the cycle and instruction counters.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_W        = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               ExtOp,
  output logic               LuOp,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         PCSource,
  output logic [3:0]         state,
  output logic               illegal_op,
  output logic               mem_timeout,
  output logic [COUNT_W-1:0] cycle_count,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11
  } state_t;

  localparam int WC_W = (TIMEOUT_CYCLES > 1) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  state_t          state_q, state_d;
  logic [WC_W-1:0] wait_q, wait_d;

  logic is_rtype, is_jr, is_jalr, is_lw, is_sw;
  logic is_mem, is_jump, is_alu_r, is_beq, is_imm;
  logic is_shift, legal, wait_st, timeout;

  always_comb begin
    is_rtype = (OpCode == 6'h00);
    is_jr    = is_rtype && (Funct == 6'h08);
    is_jalr  = is_rtype && (Funct == 6'h09);
    is_lw    = (OpCode == 6'h23);
    is_sw    = (OpCode == 6'h2B);
    is_mem   = is_lw || is_sw;
    is_jump  = is_jr || is_jalr ||
               (OpCode == 6'h02) || (OpCode == 6'h03);
    is_alu_r = is_rtype && !is_jr && !is_jalr;
    is_beq   = (OpCode == 6'h04);
    is_imm   = (OpCode == 6'h08) || (OpCode == 6'h09) ||
               (OpCode == 6'h0A) || (OpCode == 6'h0B) ||
               (OpCode == 6'h0C) || (OpCode == 6'h0F);
    is_shift = (Funct == 6'h00) || (Funct == 6'h02) ||
               (Funct == 6'h03);
    legal    = is_mem || is_jump || is_alu_r || is_beq || is_imm;
  end

  // A late mem_ready on the limit cycle still completes the access.
  always_comb begin
    wait_st = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
              (state_q == S_MEM_WRITE);
    timeout = TO_EN && wait_st && !mem_ready && (wait_q == WC_MAX);
    if (!wait_st || mem_ready || timeout) begin
      wait_d = '0;
    end else if (wait_q != WC_MAX) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FETCH;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_mem:   state_d = S_MEM_ADDR;
          is_jump:  state_d = S_JUMP;
          is_alu_r: state_d = S_EXECUTE;
          is_beq:   state_d = S_BRANCH;
          is_imm:   state_d = S_IMM_EXEC;
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:
        state_d = is_lw ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready)    state_d = S_MEM_WB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEM_WRITE: begin
        if (mem_ready || timeout) state_d = S_FETCH;
      end
      S_EXECUTE:  state_d = S_ALU_WB;
      S_IMM_EXEC: state_d = S_IMM_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Strobes are forced low while reset is held so an abort is immediate.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    ExtOp    = 1'b0;
    LuOp     = 1'b0;
    ALUSrcA  = 2'b00;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    RegDst   = 2'b00;
    MemtoReg = 2'b00;
    PCSource = 2'b00;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEM_ADDR: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          ExtOp   = 1'b1;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
        end
        S_MEM_WRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXECUTE: begin
          ALUOp   = 2'b10;
          ALUSrcA = is_shift ? 2'b10 : 2'b01;
        end
        S_ALU_WB: begin
          RegWrite = 1'b1;
          RegDst   = 2'b01;
        end
        S_BRANCH: begin
          ALUSrcA  = 2'b01;
          ALUOp    = 2'b01;
          PCSource = 2'b01;
          PCWrite  = Zero;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = is_rtype ? 2'b11 : 2'b10;
          if (OpCode == 6'h03) begin
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
          end
          if (is_jalr) begin
            RegWrite = 1'b1;
            RegDst   = 2'b01;
            MemtoReg = 2'b10;
          end
        end
        S_IMM_EXEC: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b11;
          ExtOp   = (OpCode != 6'h0C);
          LuOp    = (OpCode == 6'h0F);
        end
        S_IMM_WB: RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign illegal_op  = !reset && (state_q == S_DECODE) && !legal;
  assign mem_timeout = !reset && timeout;

`ifdef PERF_COUNTER_EN
  logic [COUNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d;
  logic               retire;

  // Only normal completions retire; illegal and timeout exits do not.
  always_comb begin
    retire = (state_q == S_MEM_WB) || (state_q == S_ALU_WB) ||
             (state_q == S_BRANCH) || (state_q == S_JUMP) ||
             (state_q == S_IMM_WB) ||
             ((state_q == S_MEM_WRITE) && mem_ready);
    cyc_d  = cyc_q + 1'b1;
    ins_d  = retire ? ins_q + 1'b1 : ins_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  assign cycle_count = cyc_q;
  assign instr_count = ins_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule
